// File: rtl/lut_access_ctrl_pkg.sv
// Shared definitions for the LUT access controller: sizes, state type and
// the power-on contents of the tap/constant table.
package lut_access_ctrl_pkg;

    localparam int unsigned LUT_DATA_W = 8;
    localparam int unsigned LUT_DEPTH  = 32;
    localparam int unsigned LUT_ADDR_W = 5;

    typedef logic [LUT_DATA_W-1:0] byte_t;

    typedef enum logic {
        SERVE = 1'b0,
        FETCH = 1'b1
    } state_e;

    // Default table contents (tap masks and constants) held by the LUT out of reset.
    function automatic byte_t lut_default(input logic [LUT_ADDR_W-1:0] a);
        byte_t v;
        case (a)
            5'd0:  v = 8'h60;
            5'd1:  v = 8'h48;
            5'd2:  v = 8'hB8;
            5'd3:  v = 8'h72;
            5'd4:  v = 8'hE1;
            5'd5:  v = 8'h1D;
            5'd6:  v = 8'h8E;
            5'd7:  v = 8'hC3;
            5'd8:  v = 8'hB4;
            5'd9:  v = 8'h2F;
            5'd10: v = 8'h5A;
            5'd11: v = 8'h96;
            5'd12: v = 8'hD4;
            5'd13: v = 8'h0B;
            5'd14: v = 8'h63;
            5'd15: v = 8'hF5;
            5'd16: v = 8'h11;
            5'd17: v = 8'h2D;
            5'd18: v = 8'h4E;
            5'd19: v = 8'h87;
            5'd20: v = 8'h9C;
            5'd21: v = 8'hA3;
            5'd22: v = 8'hC9;
            5'd23: v = 8'hEB;
            5'd24: v = 8'h01;
            5'd25: v = 8'h3F;
            5'd26: v = 8'h55;
            5'd27: v = 8'h7E;
            5'd28: v = 8'h8A;
            5'd29: v = 8'hB1;
            5'd30: v = 8'hCC;
            5'd31: v = 8'hFF;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/lut_access_ctrl_arb.sv
// Two-input round-robin arbiter: one-hot grant, pointer favours the
// requester that was not granted last.
module lut_rr_arb2 (
    input  logic       clk,
    input  logic       init,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q;   // 0: favour req[0], 1: favour req[1]
    logic ptr_d;

    // Grant selection: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer moves to the requester that did not win; holds with no grant.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (init) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/lut_access_ctrl.sv
// Shares the 32-entry byte LUT between the execute stage (req0) and the
// LFSR/tap sequencer (req1), and owns the LUT write port for reloads.
module lut_access_ctrl
    import lut_access_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = LUT_DATA_W,
    parameter int unsigned DEPTH  = LUT_DEPTH,
    parameter int unsigned ADDR_W = LUT_ADDR_W
) (
    input  logic              clk,
    input  logic              init,
    input  logic              load_start,
    output logic              cfg_rd,
    output logic [ADDR_W-1:0] cfg_addr,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              lut_we,
    output logic [ADDR_W-1:0] lut_waddr,
    output logic [DATA_W-1:0] lut_wdata,
    output logic [ADDR_W-1:0] lut_raddr,
    input  logic [DATA_W-1:0] lut_rdata,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_idx,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_idx,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              busy,
    output logic              oor_err
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cfg_addr_q, cfg_addr_d;
    logic                cfg_rd_q, cfg_rd_d;
    logic                busy_q, busy_d;
    logic                rsp0_valid_q, rsp0_valid_d;
    logic                rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0]   rsp0_data_q, rsp0_data_d;
    logic [DATA_W-1:0]   rsp1_data_q, rsp1_data_d;
    logic                oor_err_q, oor_err_d;

    logic [1:0]          arb_req;
    logic [1:0]          arb_gnt;
    logic [DATA_W-1:0]   sel_idx;
    logic                sel_oor;
    logic [DATA_W-1:0]   rd_byte;

    // Requests reach the arbiter only when a grant is allowed this cycle.
    always_comb begin
        arb_req = 2'b00;
        if (state_q == SERVE && !load_start && !init) begin
            arb_req = {req1_valid, req0_valid};
        end
    end

    lut_rr_arb2 u_arb (
        .clk  (clk),
        .init (init),
        .req  (arb_req),
        .gnt  (arb_gnt)
    );

    assign req0_ready = arb_gnt[0];
    assign req1_ready = arb_gnt[1];

    // Read path: range check on the full index, then truncate for the LUT address.
    always_comb begin
        sel_idx      = arb_gnt[1] ? req1_idx : req0_idx;
        sel_oor      = (sel_idx >= DATA_W'(DEPTH));
        lut_raddr    = (|arb_gnt) ? sel_idx[ADDR_W-1:0] : '0;
        rd_byte      = sel_oor ? '0 : lut_rdata;
        rsp0_valid_d = arb_gnt[0];
        rsp1_valid_d = arb_gnt[1];
        rsp0_data_d  = arb_gnt[0] ? rd_byte : rsp0_data_q;
        rsp1_data_d  = arb_gnt[1] ? rd_byte : rsp1_data_q;
        oor_err_d    = (|arb_gnt) && sel_oor;
    end

    // Reload sequencing: next state, fetch address and the LUT write strobe.
    always_comb begin
        state_d    = state_q;
        cfg_addr_d = cfg_addr_q;
        lut_we     = 1'b0;
        lut_waddr  = cfg_addr_q;
        lut_wdata  = cfg_data;
        case (state_q)
            SERVE: begin
                if (load_start) begin
                    state_d    = FETCH;
                    cfg_addr_d = '0;
                end
            end
            FETCH: begin
                if (cfg_valid) begin
                    // init must block the write so an abandoned reload stops cleanly
                    lut_we = !init;
                    if (cfg_addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d    = SERVE;
                        cfg_addr_d = '0;
                    end else begin
                        cfg_addr_d = cfg_addr_q + 1'b1;
                    end
                end
            end
            default: state_d = SERVE;
        endcase
        busy_d   = (state_d == FETCH);
        cfg_rd_d = (state_d == FETCH);
    end

    // State and registered outputs; init overrides everything.
    always_ff @(posedge clk) begin
        if (init) begin
            state_q      <= SERVE;
            cfg_addr_q   <= '0;
            cfg_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            oor_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_addr_q   <= cfg_addr_d;
            cfg_rd_q     <= cfg_rd_d;
            busy_q       <= busy_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
            oor_err_q    <= oor_err_d;
        end
    end

    assign cfg_addr   = cfg_addr_q;
    assign cfg_rd     = cfg_rd_q;
    assign busy       = busy_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;
    assign oor_err    = oor_err_q;

endmodule

// File: tb/tb_lut_access_ctrl.sv
// Self-checking bench for lut_access_ctrl with a behavioural LUT and config memory.
module tb_lut_access_ctrl;
    import lut_access_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       init = 1'b1;
    logic       load_start = 1'b0;
    logic       cfg_rd;
    logic [4:0] cfg_addr;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_data;
    logic       lut_we;
    logic [4:0] lut_waddr;
    logic [7:0] lut_wdata;
    logic [4:0] lut_raddr;
    logic [7:0] lut_rdata;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_idx = '0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_idx = '0;
    logic       req1_ready;
    logic       rsp0_valid;
    logic [7:0] rsp0_data;
    logic       rsp1_valid;
    logic [7:0] rsp1_data;
    logic       busy;
    logic       oor_err;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference model state
    logic [7:0] exp_lut [32];
    bit         favour;          // 0: req0 wins a tie, 1: req1 wins a tie
    logic [7:0] exp_d0, exp_d1;  // last response bytes

    // Behavioural LUT and configuration source
    logic       tb_preload = 1'b1;
    logic [7:0] lut_mem [32];
    logic [7:0] cfg_mem [32];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_preload) begin
            for (int i = 0; i < 32; i++) lut_mem[i] <= lut_default(5'(i));
        end else if (lut_we) begin
            lut_mem[lut_waddr] <= lut_wdata;
        end
    end
    assign lut_rdata = lut_mem[lut_raddr];
    assign cfg_data  = cfg_mem[cfg_addr];

    lut_access_ctrl #(.DATA_W(8), .DEPTH(32), .ADDR_W(5)) dut (
        .clk(clk), .init(init), .load_start(load_start),
        .cfg_rd(cfg_rd), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .lut_raddr(lut_raddr), .lut_rdata(lut_rdata),
        .req0_valid(req0_valid), .req0_idx(req0_idx), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_idx(req1_idx), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .busy(busy), .oor_err(oor_err)
    );

    task automatic drive_idle;
        init = 1'b0; load_start = 1'b0; cfg_valid = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_idx = '0; req1_idx = '0;
    endtask

    task automatic do_init;
        @(negedge clk); drive_idle(); init = 1'b1;
        @(negedge clk); init = 1'b0;
        favour = 1'b0; exp_d0 = '0; exp_d1 = '0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        drive_idle(); init = 1'b1; load_start = 1'b1; cfg_valid = 1'b1; req0_valid = 1'b1;
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
        tests++; if (cfg_rd !== 1'b0) begin fails++; $display("FAIL reset_cfg_rd: got %b exp 0", cfg_rd); end
        tests++; if (cfg_addr !== 5'd0) begin fails++; $display("FAIL reset_cfg_addr: got %h exp 00", cfg_addr); end
        tests++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b%b exp 00", rsp1_valid, rsp0_valid); end
        tests++; if (rsp0_data !== 8'h00 || rsp1_data !== 8'h00) begin fails++; $display("FAIL reset_rsp_data: got %h/%h exp 00/00", rsp0_data, rsp1_data); end
        tests++; if (oor_err !== 1'b0) begin fails++; $display("FAIL reset_oor_err: got %b exp 0", oor_err); end
        @(negedge clk); drive_idle();
        #1;
        tests++; if (lut_we !== 1'b0) begin fails++; $display("FAIL reset_lut_we: got %b exp 0", lut_we); end
        favour = 1'b0; exp_d0 = '0; exp_d1 = '0;
    endtask

    task automatic test_single_read;
        @(negedge clk); drive_idle(); req0_valid = 1'b1; req0_idx = 8'd3;
        #1;
        tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin fails++; $display("FAIL single_ready: got %b%b exp 01", req1_ready, req0_ready); end
        tests++; if (lut_raddr !== 5'd3) begin fails++; $display("FAIL single_raddr: got %0d exp 3", lut_raddr); end
        @(posedge clk); #1;
        tests++; if (rsp0_valid !== 1'b1 || rsp0_data !== 8'h72) begin fails++; $display("FAIL single_rsp: got v=%b d=%h exp v=1 d=72", rsp0_valid, rsp0_data); end
        favour = 1'b1; exp_d0 = 8'h72;
        @(negedge clk); drive_idle();
        @(posedge clk); #1;
        tests++; if (rsp0_valid !== 1'b0 || rsp0_data !== 8'h72) begin fails++; $display("FAIL single_hold: got v=%b d=%h exp v=0 d=72", rsp0_valid, rsp0_data); end
    endtask

    task automatic test_round_robin;
        do_init();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); req0_valid = 1'b1; req0_idx = 8'd0; req1_valid = 1'b1; req1_idx = 8'd1;
            #1;
            tests++; if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin fails++; $display("FAIL rr_grant_%0d: got %b%b exp req%0d", k, req1_ready, req0_ready, k % 2); end
            @(posedge clk); #1;
            if (k % 2 == 0) begin
                tests++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_data !== 8'h60) begin fails++; $display("FAIL rr_rsp_%0d: got v=%b%b d0=%h exp v=01 d0=60", k, rsp1_valid, rsp0_valid, rsp0_data); end
            end else begin
                tests++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_data !== 8'h48) begin fails++; $display("FAIL rr_rsp_%0d: got v=%b%b d1=%h exp v=10 d1=48", k, rsp1_valid, rsp0_valid, rsp1_data); end
            end
        end
        favour = 1'b0; exp_d0 = 8'h60; exp_d1 = 8'h48;
        @(negedge clk); drive_idle();
    endtask

    task automatic test_out_of_range;
        // req0 alone makes req1 the favoured side
        @(negedge clk); drive_idle(); req0_valid = 1'b1; req0_idx = 8'd2;
        @(posedge clk); #1;
        tests++; if (rsp0_valid !== 1'b1 || rsp0_data !== exp_lut[2]) begin fails++; $display("FAIL oor_pre: got v=%b d=%h exp v=1 d=%h", rsp0_valid, rsp0_data, exp_lut[2]); end
        @(negedge clk); drive_idle(); req1_valid = 1'b1; req1_idx = 8'd40;
        #1;
        tests++; if (req1_ready !== 1'b1 || lut_raddr !== 5'd8) begin fails++; $display("FAIL oor_grant: got rdy=%b raddr=%0d exp rdy=1 raddr=8", req1_ready, lut_raddr); end
        @(posedge clk); #1;
        tests++; if (rsp1_valid !== 1'b1 || rsp1_data !== 8'h00 || oor_err !== 1'b1) begin fails++; $display("FAIL oor_rsp: got v=%b d=%h err=%b exp v=1 d=00 err=1", rsp1_valid, rsp1_data, oor_err); end
        // After the req1 grant a tie must go to req0 (boundary idx 31 in range)
        @(negedge clk); req0_valid = 1'b1; req0_idx = 8'd31; req1_valid = 1'b1; req1_idx = 8'd32;
        #1;
        tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || lut_raddr !== 5'd31) begin fails++; $display("FAIL oor_flip: got rdy=%b%b raddr=%0d exp 01 raddr=31", req1_ready, req0_ready, lut_raddr); end
        @(posedge clk); #1;
        tests++; if (rsp0_valid !== 1'b1 || rsp0_data !== exp_lut[31] || oor_err !== 1'b0) begin fails++; $display("FAIL idx31_rsp: got v=%b d=%h err=%b exp v=1 d=%h err=0", rsp0_valid, rsp0_data, oor_err, exp_lut[31]); end
        @(negedge clk);
        #1;
        tests++; if (req1_ready !== 1'b1 || lut_raddr !== 5'd0) begin fails++; $display("FAIL idx32_grant: got rdy=%b raddr=%0d exp rdy=1 raddr=0", req1_ready, lut_raddr); end
        @(posedge clk); #1;
        tests++; if (rsp1_valid !== 1'b1 || rsp1_data !== 8'h00 || oor_err !== 1'b1) begin fails++; $display("FAIL idx32_rsp: got v=%b d=%h err=%b exp v=1 d=00 err=1", rsp1_valid, rsp1_data, oor_err); end
        @(negedge clk); drive_idle();
        @(posedge clk); #1;
        tests++; if (oor_err !== 1'b0 || rsp1_valid !== 1'b0) begin fails++; $display("FAIL oor_pulse: got err=%b v=%b exp 0 0", oor_err, rsp1_valid); end
        favour = 1'b0; exp_d0 = exp_lut[31]; exp_d1 = 8'h00;
    endtask

    task automatic test_reload;
        int unsigned busy_cnt;
        int unsigned bad;
        for (int a = 0; a < 32; a++) cfg_mem[a] = 8'hA0 + 8'(a);
        @(negedge clk); drive_idle(); load_start = 1'b1;
        @(posedge clk); #1;
        tests++; if (busy !== 1'b1 || cfg_rd !== 1'b1 || cfg_addr !== 5'd0) begin fails++; $display("FAIL reload_enter: got busy=%b rd=%b addr=%0d exp 1 1 0", busy, cfg_rd, cfg_addr); end
        busy_cnt = 0; bad = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            load_start = (k == 5); cfg_valid = 1'b1;
            req0_valid = 1'b1; req0_idx = 8'($urandom_range(0, 31));
            req1_valid = 1'b1; req1_idx = 8'($urandom_range(0, 31));
            #1;
            if (busy === 1'b1) busy_cnt++;
            tests++; if (lut_we !== 1'b1 || lut_waddr !== 5'(k) || lut_wdata !== 8'hA0 + 8'(k) || cfg_addr !== 5'(k)) begin fails++; bad++; $display("FAIL reload_write_%0d: got we=%b a=%0d d=%h ca=%0d exp we=1 a=%0d d=%h", k, lut_we, lut_waddr, lut_wdata, cfg_addr, k, 8'hA0 + 8'(k)); end
            tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin fails++; $display("FAIL reload_ready_%0d: got %b%b exp 00", k, req1_ready, req0_ready); end
            @(posedge clk); #1;
            tests++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin fails++; $display("FAIL reload_rsp_%0d: got %b%b exp 00", k, rsp1_valid, rsp0_valid); end
            exp_lut[k] = 8'hA0 + 8'(k);
        end
        @(negedge clk); drive_idle();
        #1;
        tests++; if (busy !== 1'b0 || cfg_rd !== 1'b0) begin fails++; $display("FAIL reload_exit: got busy=%b rd=%b exp 0 0", busy, cfg_rd); end
        tests++; if (busy_cnt != 32) begin fails++; $display("FAIL reload_busy_len: got %0d exp 32", busy_cnt); end
        req0_valid = 1'b1; req0_idx = 8'd5;
        @(posedge clk); #1;
        tests++; if (rsp0_valid !== 1'b1 || rsp0_data !== 8'hA5) begin fails++; $display("FAIL reload_read5: got v=%b d=%h exp v=1 d=a5", rsp0_valid, rsp0_data); end
        favour = 1'b1; exp_d0 = 8'hA5;
        @(negedge clk); drive_idle();
    endtask

    task automatic test_reload_abort;
        int unsigned writes;
        bit          done;
        for (int a = 0; a < 32; a++) cfg_mem[a] = 8'h30 + 8'(a);
        @(negedge clk); drive_idle(); load_start = 1'b1;
        @(posedge clk); #1;
        writes = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            load_start = 1'b0;
            cfg_valid  = (i % 3 == 2);
            if (cfg_valid && writes == 10) init = 1'b1;
            #1;
            if (init) begin
                tests++; if (lut_we !== 1'b0) begin fails++; $display("FAIL abort_we_blocked: got %b exp 0", lut_we); end
            end else begin
                tests++; if (lut_we !== cfg_valid) begin fails++; $display("FAIL abort_we_%0d: got %b exp %b", i, lut_we, cfg_valid); end
                if (lut_we === 1'b1) begin
                    tests++; if (lut_waddr !== 5'(writes) || lut_wdata !== 8'h30 + 8'(writes)) begin fails++; $display("FAIL abort_write_%0d: got a=%0d d=%h exp a=%0d d=%h", writes, lut_waddr, lut_wdata, writes, 8'h30 + 8'(writes)); end
                    writes++;
                end
            end
            @(posedge clk); #1;
            if (init) begin
                done = 1'b1;
                tests++; if (busy !== 1'b0 || cfg_rd !== 1'b0 || cfg_addr !== 5'd0) begin fails++; $display("FAIL abort_state: got busy=%b rd=%b addr=%0d exp 0 0 0", busy, cfg_rd, cfg_addr); end
            end
        end
        tests++; if (!done) begin fails++; $display("FAIL abort_timeout: got writes=%0d exp 10 within 200 cycles", writes); end
        @(negedge clk); drive_idle();
        for (int a = 0; a < 10; a++) exp_lut[a] = 8'h30 + 8'(a);
        favour = 1'b0; exp_d0 = '0; exp_d1 = '0;
        for (int a = 0; a < 11; a++) begin
            tests++; if (lut_mem[a] !== exp_lut[a]) begin fails++; $display("FAIL abort_entry_%0d: got %h exp %h", a, lut_mem[a], exp_lut[a]); end
        end
        req0_valid = 1'b1; req0_idx = 8'd9;
        @(posedge clk); #1;
        tests++; if (rsp0_valid !== 1'b1 || rsp0_data !== 8'h39) begin fails++; $display("FAIL abort_read9: got v=%b d=%h exp v=1 d=39", rsp0_valid, rsp0_data); end
        @(negedge clk); drive_idle(); req1_valid = 1'b1; req1_idx = 8'd10;
        @(posedge clk); #1;
        tests++; if (rsp1_valid !== 1'b1 || rsp1_data !== 8'hAA) begin fails++; $display("FAIL abort_read10: got v=%b d=%h exp v=1 d=aa", rsp1_valid, rsp1_data); end
        favour = 1'b0; exp_d0 = 8'h39; exp_d1 = 8'hAA;
        @(negedge clk); drive_idle();
    endtask

    task automatic test_load_collision;
        @(negedge clk); drive_idle(); req1_valid = 1'b1; req1_idx = 8'd4;
        @(posedge clk);
        @(negedge clk); drive_idle(); req0_valid = 1'b1; req0_idx = 8'd7; load_start = 1'b1;
        #1;
        tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin fails++; $display("FAIL collide_ready: got %b%b exp 00", req1_ready, req0_ready); end
        tests++; if (rsp1_valid !== 1'b1 || rsp1_data !== exp_lut[4]) begin fails++; $display("FAIL collide_inflight: got v=%b d=%h exp v=1 d=%h", rsp1_valid, rsp1_data, exp_lut[4]); end
        @(posedge clk); #1;
        tests++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL collide_after: got v=%b%b busy=%b exp 00 1", rsp1_valid, rsp0_valid, busy); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); load_start = 1'b1; cfg_valid = 1'b0;
            #1;
            tests++; if (lut_we !== 1'b0 || req0_ready !== 1'b0) begin fails++; $display("FAIL fetch_ls_%0d: got we=%b rdy=%b exp 0 0", k, lut_we, req0_ready); end
            @(posedge clk); #1;
            tests++; if (cfg_addr !== 5'd0 || busy !== 1'b1 || cfg_rd !== 1'b1) begin fails++; $display("FAIL fetch_hold_%0d: got addr=%0d busy=%b rd=%b exp 0 1 1", k, cfg_addr, busy, cfg_rd); end
        end
        for (int a = 0; a < 32; a++) cfg_mem[a] = exp_lut[a];
        for (int k = 0; k < 32; k++) begin
            @(negedge clk); load_start = 1'b0; req0_valid = 1'b0; cfg_valid = 1'b1;
        end
        @(negedge clk); drive_idle();
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL collide_exit: got busy=%b exp 0", busy); end
        favour = 1'b0; exp_d1 = exp_lut[4];
    endtask

    task automatic test_random;
        int         g;
        logic [7:0] i0, i1, isel;
        bit         v0, v1, oor;
        do_init();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            for (int s = 0; s < 2; s++) begin
                int unsigned r;
                logic [7:0]  x;
                r = $urandom_range(0, 7);
                if (r == 0) x = 8'd31;
                else if (r == 1) x = 8'd32;
                else if (r == 2) x = 8'($urandom_range(32, 255));
                else x = 8'($urandom_range(0, 31));
                if (s == 0) i0 = x; else i1 = x;
            end
            req0_valid = v0; req0_idx = i0; req1_valid = v1; req1_idx = i1;
            cfg_valid = 1'($urandom_range(0, 1));
            if (!v0 && !v1) g = -1;
            else if (v0 && (!v1 || !favour)) g = 0;
            else g = 1;
            isel = (g == 1) ? i1 : i0;
            #1;
            tests++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin fails++; $display("FAIL rand_grant_%0d: got %b%b exp g=%0d", n, req1_ready, req0_ready, g); end
            tests++; if (lut_raddr !== ((g < 0) ? 5'd0 : 5'(isel % 32))) begin fails++; $display("FAIL rand_raddr_%0d: got %0d exp %0d", n, lut_raddr, (g < 0) ? 0 : isel % 32); end
            tests++; if (lut_we !== 1'b0 || cfg_rd !== 1'b0) begin fails++; $display("FAIL rand_idle_cfg_%0d: got we=%b rd=%b exp 0 0", n, lut_we, cfg_rd); end
            oor = (g >= 0) && (isel >= 8'd32);
            if (g == 0) begin exp_d0 = oor ? 8'h00 : exp_lut[isel % 32]; favour = 1'b1; end
            if (g == 1) begin exp_d1 = oor ? 8'h00 : exp_lut[isel % 32]; favour = 1'b0; end
            @(posedge clk); #1;
            tests++; if (rsp0_valid !== (g == 0) || rsp1_valid !== (g == 1)) begin fails++; $display("FAIL rand_rsp_valid_%0d: got %b%b exp g=%0d", n, rsp1_valid, rsp0_valid, g); end
            tests++; if (rsp0_data !== exp_d0 || rsp1_data !== exp_d1) begin fails++; $display("FAIL rand_rsp_data_%0d: got %h/%h exp %h/%h", n, rsp0_data, rsp1_data, exp_d0, exp_d1); end
            tests++; if (oor_err !== oor) begin fails++; $display("FAIL rand_oor_%0d: got %b exp %b", n, oor_err, oor); end
        end
        @(negedge clk); drive_idle();
    endtask

    initial begin
        for (int a = 0; a < 32; a++) begin
            exp_lut[a] = lut_default(5'(a));
            cfg_mem[a] = 8'h00;
        end
        favour = 1'b0; exp_d0 = '0; exp_d1 = '0;
        @(posedge clk); #1; tb_preload = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_out_of_range();
        test_reload();
        test_reload_abort();
        test_load_collision();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
